// File: rtl/unidade_controle_rodadas_if.sv
// Control/status bundle between the round-game control unit and its datapath.
// master = control unit (drives enables and verdicts), slave = datapath/top side.
interface unidade_controle_rodadas_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimE;
  logic       fimL;
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, fimE, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, timeout, pronto, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, fimE, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, timeout, pronto, db_estado
  );
endinterface

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the round-based memory game: sequences the E/L counters,
// play register and comparator, and times out a play left idle in espera.
module unidade_controle_rodadas #(
  parameter int TIMEOUT = 3000,
  parameter int W_TO    = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  unidade_controle_rodadas_if.master  bus
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FINAL_ACERTO   = 4'hA,
    FINAL_TIMEOUT  = 4'hD,
    FINAL_ERRO     = 4'hE
  } estado_t;

  localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT - 1);

  estado_t         state_q, state_d;
  logic [W_TO-1:0] timer_q, timer_d;

  // Timer only runs in espera, so every play starts from a fresh window.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      INICIAL:        if (bus.iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = INICIO_RODADA;
      INICIO_RODADA:  state_d = ESPERA;
      ESPERA: begin
        timer_d = timer_q + 1'b1;
        if (bus.jogada)             state_d = REGISTRA;
        else if (timer_q == TO_LAST) state_d = FINAL_TIMEOUT;
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual)     state_d = FINAL_ERRO;
        else if (!bus.fimE) state_d = PROXIMA;
        else if (!bus.fimL) state_d = PROXIMA_RODADA;
        else                state_d = FINAL_ACERTO;
      end
      PROXIMA:        state_d = ESPERA;
      PROXIMA_RODADA: state_d = INICIO_RODADA;
      FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT:
                      if (bus.iniciar) state_d = PREPARACAO;
      default:        state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Outputs depend on the current state only; reset forces inicial immediately.
  always_comb begin
    bus.zeraE     = 1'b0;
    bus.contaE    = 1'b0;
    bus.zeraL     = 1'b0;
    bus.contaL    = 1'b0;
    bus.zeraR     = 1'b0;
    bus.registraR = 1'b0;
    bus.acertou   = 1'b0;
    bus.errou     = 1'b0;
    bus.timeout   = 1'b0;
    bus.db_estado = 4'hF;
    case (state_q)
      INICIAL, PREPARACAO: begin
        bus.zeraE = 1'b1;
        bus.zeraL = 1'b1;
        bus.zeraR = 1'b1;
        bus.db_estado = state_q;
      end
      INICIO_RODADA:  begin bus.zeraE     = 1'b1; bus.db_estado = state_q; end
      ESPERA:         bus.db_estado = state_q;
      REGISTRA:       begin bus.registraR = 1'b1; bus.db_estado = state_q; end
      COMPARACAO:     bus.db_estado = state_q;
      PROXIMA:        begin bus.contaE    = 1'b1; bus.db_estado = state_q; end
      PROXIMA_RODADA: begin bus.contaL    = 1'b1; bus.db_estado = state_q; end
      FINAL_ACERTO:   begin bus.acertou   = 1'b1; bus.db_estado = state_q; end
      FINAL_ERRO:     begin bus.errou     = 1'b1; bus.db_estado = state_q; end
      FINAL_TIMEOUT:  begin bus.timeout   = 1'b1; bus.db_estado = state_q; end
      default:        bus.db_estado = 4'hF;
    endcase
  end

  assign bus.pronto = bus.acertou | bus.errou | bus.timeout;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench: small datapath model (3 rounds) around the control unit, TIMEOUT=8.
module tb_unidade_controle_rodadas;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nchk  = 0;
  int   nerr  = 0;
  int   ncontaL = 0;
  int   base;
  logic [1:0] mE = '0, mL = '0;

  unidade_controle_rodadas_if bus();

  unidade_controle_rodadas #(.TIMEOUT(8), .W_TO(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Datapath model: address counter E, round counter L (rounds 0..2).
  always @(posedge clock) begin
    if (bus.zeraE)       mE <= '0;
    else if (bus.contaE) mE <= mE + 2'd1;
    if (bus.zeraL)       mL <= '0;
    else if (bus.contaL) mL <= mL + 2'd1;
    if (bus.contaL)      ncontaL <= ncontaL + 1;
  end
  assign bus.fimE = (mE == mL);
  assign bus.fimL = (mL == 2'd2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic restart();
    bus.iniciar = 1'b1;
    step();
    chk("prep_state", bus.db_estado, 4'h1);
    chk("prep_zeraL", bus.zeraL, 1);
    bus.iniciar = 1'b0;
    step();
    chk("inicio_state", bus.db_estado, 4'h2);
    chk("inicio_zeraE", bus.zeraE, 1);
    step();
    chk("espera_state", bus.db_estado, 4'h3);
  endtask

  // One play from espera; hold keeps jogada high through registra..verdict.
  task automatic play(input logic ok, input logic hold, input logic [3:0] verdict);
    bus.igual  = ok;
    bus.jogada = 1'b1;
    step();
    chk("registra_state", bus.db_estado, 4'h4);
    chk("registraR", bus.registraR, 1);
    if (!hold) bus.jogada = 1'b0;
    step();
    chk("comparacao_state", bus.db_estado, 4'h5);
    step();
    chk("verdict_state", bus.db_estado, verdict);
    bus.jogada = 1'b0;
    if (verdict == 4'h6) begin
      chk("proxima_contaE", bus.contaE, 1);
      step();
      chk("back_espera", bus.db_estado, 4'h3);
    end else if (verdict == 4'h7) begin
      chk("prox_rodada_contaL", bus.contaL, 1);
      step();
      chk("new_round_state", bus.db_estado, 4'h2);
      step();
      chk("new_round_espera", bus.db_estado, 4'h3);
    end
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    #1;
    chk("rst_state", bus.db_estado, 4'h0);
    chk("rst_zeras", {bus.zeraE, bus.zeraL, bus.zeraR}, 3'b111);
    chk("rst_pronto", bus.pronto, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("idle_state", bus.db_estado, 4'h0);
    restart();

    // Win: rounds of 1, 2, 3 plays; one play holds jogada to show it is ignored.
    base = ncontaL;
    play(1, 0, 4'h7);
    play(1, 1, 4'h6);
    play(1, 0, 4'h7);
    play(1, 0, 4'h6);
    play(1, 0, 4'h6);
    play(1, 0, 4'hA);
    chk("win_contaL_pulses", ncontaL - base, 2);
    chk("win_flags", {bus.acertou, bus.errou, bus.timeout, bus.pronto}, 4'b1001);
    bus.jogada = 1'b1;
    step();
    chk("final_jogada_ignored", bus.db_estado, 4'hA);
    bus.jogada = 1'b0;
    restart();

    // Lose on second play of round 1.
    play(1, 0, 4'h7);
    base = ncontaL;
    play(1, 0, 4'h6);
    play(0, 0, 4'hE);
    chk("err_no_contaL", ncontaL - base, 0);
    chk("err_flags", {bus.acertou, bus.errou, bus.timeout, bus.pronto}, 4'b0101);
    restart();

    // Timeout: 8th idle edge in espera.
    for (int i = 0; i < 7; i++) begin
      step();
      chk("wait_espera", bus.db_estado, 4'h3);
    end
    step();
    chk("to_state", bus.db_estado, 4'hD);
    chk("to_flags", {bus.acertou, bus.errou, bus.timeout, bus.pronto}, 4'b0011);
    restart();

    // jogada in the same cycle as the timer limit wins.
    for (int i = 0; i < 7; i++) step();
    chk("tie_pre_state", bus.db_estado, 4'h3);
    bus.igual  = 1'b1;
    bus.jogada = 1'b1;
    step();
    bus.jogada = 1'b0;
    chk("tie_registra", bus.db_estado, 4'h4);
    chk("tie_no_timeout", bus.timeout, 0);
    step();
    step();
    chk("tie_verdict", bus.db_estado, 4'h7);
    step();
    step();
    chk("tie_espera", bus.db_estado, 4'h3);

    // Asynchronous reset mid-espera, away from any clock edge.
    step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_state", bus.db_estado, 4'h0);
    chk("midrst_zeras", {bus.zeraE, bus.zeraL, bus.zeraR}, 3'b111);
    chk("midrst_others", {bus.contaE, bus.contaL, bus.registraR, bus.pronto}, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("post_rst_idle", bus.db_estado, 4'h0);
    restart();
    for (int i = 0; i < 7; i++) step();
    chk("post_rst_timer_fresh", bus.db_estado, 4'h3);
    step();
    chk("post_rst_timeout", bus.db_estado, 4'hD);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
